sd_spi_ctrl: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 28 ++
 rtl/sd_spi_baud.sv | 26 ++
 rtl/sd_spi_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sd_spi_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - register map, FSM states and CTRL/STAT bit positions for sd_spi_ctrl
package sd_spi_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // CTRL write bits
  localparam int CTRL_SSEL   = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 7;

  // STAT read bits
  localparam int STAT_SSEL   = 0;
  localparam int STAT_IRQ_EN = 1;
  localparam int STAT_MISO   = 3;
  localparam int STAT_DET    = 4;
  localparam int STAT_PEND   = 5;
  localparam int STAT_OVR    = 6;
  localparam int STAT_BUSY   = 7;

endpackage

// File: rtl/sd_spi_baud.sv
// rtl/sd_spi_baud.sv - reloadable half-period down-counter for the SPI clock
module sd_spi_baud (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       enable,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else if (start) begin
      count_q <= load_val;
    end else if (count_q != 8'd0) begin
      count_q <= count_q - 8'd1;
    end
  end

  // A load of N expires after N+1 cycles; the FSM reloads on the expire cycle.
  assign expire = enable && (count_q == 8'd0);

endmodule

// File: rtl/sd_spi_ctrl.sv
// rtl/sd_spi_ctrl.sv - byte-wide SPI mode-0 master for the SD card with a 4-register CPU window
// Optional transfer-complete interrupt output enabled by defining SD_SPI_IRQ_EN.
module sd_spi_ctrl
  import sd_spi_pkg::*;
#(
  parameter logic [7:0] CLK_DIV_RESET = 8'd45
) (
  input  logic       phi,
  input  logic       reset_n,
  input  logic       wr_tick,
  input  logic       rd_tick,
  input  logic [1:0] reg_sel,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       sd_clk,
  output logic       sd_mosi,
  output logic       sd_ssel_n,
  input  logic       sd_miso,
  input  logic       sd_det
`ifdef SD_SPI_IRQ_EN
  ,
  output logic       irq
`endif
);

  state_t     state_q, state_d;
  logic       baud_start, expire;
  logic       sck_rise, sck_fall, xfer_done;
  logic [7:0] tx_q, rx_q, data_q, div_q, div_work_q;
  logic [2:0] bitcnt_q;
  logic       ovr_q, pend_q, irq_en_q;
  logic       data_wr, ctrl_wr, div_wr, launch, ovr_set, ctrl_clr;

  // Reads have no side effects in this block.
  logic rd_tick_unused;
  assign rd_tick_unused = rd_tick;

  assign data_wr  = wr_tick && (reg_sel == REG_DATA);
  assign ctrl_wr  = wr_tick && (reg_sel == REG_CTRL);
  assign div_wr   = wr_tick && (reg_sel == REG_DIV);
  assign launch   = data_wr && (state_q == ST_IDLE);
  assign ovr_set  = data_wr && (state_q != ST_IDLE);
  assign ctrl_clr = ctrl_wr && din[CTRL_CLR];
  assign busy     = (state_q != ST_IDLE);

  // The working divider is latched at launch so DIV writes mid-transfer wait for the next byte.
  sd_spi_baud u_baud (
    .clk      (phi),
    .reset_n  (reset_n),
    .start    (baud_start),
    .enable   (busy),
    .load_val (launch ? div_q : div_work_q),
    .expire   (expire)
  );

  always_ff @(posedge phi) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_start = 1'b0;
    sck_rise   = 1'b0;
    sck_fall   = 1'b0;
    xfer_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          baud_start = 1'b1;
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (expire) begin
          sck_rise   = 1'b1;
          baud_start = 1'b1;
          state_d    = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (expire) begin
          sck_fall = 1'b1;
          if (bitcnt_q == 3'd7) begin
            xfer_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            baud_start = 1'b1;
            state_d    = ST_LOW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi) begin
    if (!reset_n) begin
      tx_q       <= 8'd0;
      rx_q       <= 8'd0;
      bitcnt_q   <= 3'd0;
      div_work_q <= 8'd0;
      sd_clk     <= 1'b0;
      sd_mosi    <= 1'b1;
    end else begin
      if (launch) begin
        tx_q       <= din;
        sd_mosi    <= din[7];
        bitcnt_q   <= 3'd0;
        div_work_q <= div_q;
      end
      if (sck_rise) begin
        sd_clk <= 1'b1;
        rx_q   <= {rx_q[6:0], sd_miso};
      end
      if (sck_fall) begin
        sd_clk <= 1'b0;
        if (xfer_done) begin
          sd_mosi <= 1'b1;
        end else begin
          tx_q     <= {tx_q[6:0], 1'b0};
          sd_mosi  <= tx_q[6];
          bitcnt_q <= bitcnt_q + 3'd1;
        end
      end
    end
  end

  // Completion beats a same-cycle clear so a finishing byte is never lost.
  always_ff @(posedge phi) begin
    if (!reset_n) begin
      data_q    <= 8'hFF;
      div_q     <= CLK_DIV_RESET;
      sd_ssel_n <= 1'b1;
      ovr_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      if (xfer_done) data_q <= rx_q;
      if (ctrl_wr) sd_ssel_n <= din[CTRL_SSEL];
      if (div_wr) div_q <= din;
      ovr_q  <= ovr_set | (ovr_q & ~ctrl_clr);
      pend_q <= xfer_done | (pend_q & ~ctrl_clr);
    end
  end

`ifdef SD_SPI_IRQ_EN
  always_ff @(posedge phi) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= din[CTRL_IRQ_EN];
      irq <= pend_q & irq_en_q;
    end
  end
`else
  assign irq_en_q = 1'b0;
`endif

  always_comb begin
    dout = 8'hFF;
    case (reg_sel)
      REG_DATA: dout = data_q;
      REG_CTRL: begin
        dout              = 8'h00;
        dout[STAT_BUSY]   = busy;
        dout[STAT_OVR]    = ovr_q;
        dout[STAT_PEND]   = pend_q;
        dout[STAT_DET]    = sd_det;
        dout[STAT_MISO]   = sd_miso;
        dout[STAT_IRQ_EN] = irq_en_q;
        dout[STAT_SSEL]   = sd_ssel_n;
      end
      REG_DIV:  dout = div_q;
      default:  dout = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// tb/tb_sd_spi_ctrl.sv - scoreboard bench for sd_spi_ctrl; irq scenario built only with SD_SPI_IRQ_EN
module tb_sd_spi_ctrl;

  logic       phi = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_tick = 1'b0;
  logic       rd_tick = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic       busy, sd_clk, sd_mosi, sd_ssel_n;
  logic       sd_miso;
  logic       sd_det = 1'b1;
`ifdef SD_SPI_IRQ_EN
  logic       irq;
`endif

  bit         loop_mode = 1'b1;
  logic [7:0] slave_q = 8'hFF;
  assign sd_miso = loop_mode ? sd_mosi : slave_q[7];

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_mosi_q[$];
  logic [7:0] exp_rx_q[$];

  logic [7:0] mon_shift = 8'd0;
  int  mon_bits = 0;
  int  cur_len = 0, last_len = 0, xfers_done = 0;
  int  first_rise = -1, first_fall = -1;
  logic sck_prev = 1'b0;
  bit  mosi_low = 1'b0;

  sd_spi_ctrl dut (
    .phi       (phi),
    .reset_n   (reset_n),
    .wr_tick   (wr_tick),
    .rd_tick   (rd_tick),
    .reg_sel   (reg_sel),
    .din       (din),
    .dout      (dout),
    .busy      (busy),
    .sd_clk    (sd_clk),
    .sd_mosi   (sd_mosi),
    .sd_ssel_n (sd_ssel_n),
    .sd_miso   (sd_miso),
    .sd_det    (sd_det)
`ifdef SD_SPI_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 phi = ~phi;

  always @(posedge sd_clk) begin
    mon_shift = {mon_shift[6:0], sd_mosi};
    mon_bits++;
  end

  always @(negedge sd_clk) slave_q = {slave_q[6:0], 1'b1};

  always @(negedge phi) begin
    if (busy === 1'b1) begin
      if (cur_len == 0) begin
        first_rise = -1;
        first_fall = -1;
      end
      if (sd_clk && !sck_prev && first_rise < 0) first_rise = cur_len;
      if (!sd_clk && sck_prev && first_fall < 0) first_fall = cur_len;
      if (sd_mosi !== 1'b1) mosi_low = 1'b1;
      cur_len++;
    end else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
      xfers_done++;
    end
    sck_prev = sd_clk;
  end

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge phi);
    reg_sel = a;
    din     = d;
    wr_tick = 1'b1;
    @(negedge phi);
    wr_tick = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge phi);
    reg_sel = a;
    #1 d = dout;
  endtask

  task automatic wait_xfer(input int n0, output bit ok);
    int k = 0;
    while (xfers_done == n0 && k < 5000) begin
      @(negedge phi);
      k++;
    end
    ok = (xfers_done != n0);
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] rx, output bit ok);
    int n0;
    n0       = xfers_done;
    mon_bits = 0;
    mosi_low = 1'b0;
    exp_mosi_q.push_back(tx);
    exp_rx_q.push_back(rx);
    cpu_write(2'd0, tx);
    wait_xfer(n0, ok);
  endtask

  task automatic test_reset;
    logic [7:0] v;
    repeat (3) @(negedge phi);
    reset_n = 1'b1;
    @(negedge phi);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (sd_clk !== 1'b0) $display("FAIL reset_sck: got %b want 0", sd_clk); else passed++;
    checks++; if (sd_mosi !== 1'b1) $display("FAIL reset_mosi: got %b want 1", sd_mosi); else passed++;
    checks++; if (sd_ssel_n !== 1'b1) $display("FAIL reset_ssel: got %b want 1", sd_ssel_n); else passed++;
    cpu_read(2'd0, v);
    checks++; if (v !== 8'hFF) $display("FAIL reset_data: got %h want ff", v); else passed++;
    cpu_read(2'd2, v);
    checks++; if (v !== 8'd45) $display("FAIL reset_div: got %h want 2d", v); else passed++;
    cpu_read(2'd1, v);
    checks++; if (v !== 8'h19) $display("FAIL reset_stat: got %h want 19", v); else passed++;
    cpu_write(2'd3, 8'h00);
    cpu_read(2'd3, v);
    checks++; if (v !== 8'hFF) $display("FAIL reg3_read: got %h want ff", v); else passed++;
  endtask

  task automatic test_loopback;
    logic [7:0] v, e;
    bit ok;
    cpu_write(2'd2, 8'd0);
    cpu_write(2'd1, 8'h00);
    run_xfer(8'hA5, 8'hA5, ok);
    checks++; if (!ok) $display("FAIL loop_timeout: got no completion want completion"); else passed++;
    e = exp_mosi_q.pop_front();
    checks++; if (mon_shift !== e) $display("FAIL loop_mosi: got %h want %h", mon_shift, e); else passed++;
    checks++; if (mon_bits != 8) $display("FAIL loop_sck_pulses: got %0d want 8", mon_bits); else passed++;
    checks++; if (last_len != 16) $display("FAIL loop_busy_len: got %0d want 16", last_len); else passed++;
    checks++; if (first_rise != 1) $display("FAIL loop_first_rise: got %0d want 1", first_rise); else passed++;
    cpu_read(2'd0, v);
    e = exp_rx_q.pop_front();
    checks++; if (v !== e) $display("FAIL loop_data: got %h want %h", v, e); else passed++;
    cpu_read(2'd1, v);
    checks++; if (v !== 8'h38) $display("FAIL loop_stat: got %h want 38", v); else passed++;
    checks++; if (sd_ssel_n !== 1'b0) $display("FAIL loop_ssel: got %b want 0", sd_ssel_n); else passed++;
  endtask

  task automatic test_overrun;
    logic [7:0] v, e;
    bit ok;
    int n0;
    cpu_write(2'd2, 8'd2);
    n0       = xfers_done;
    mon_bits = 0;
    exp_mosi_q.push_back(8'h3C);
    exp_rx_q.push_back(8'h3C);
    cpu_write(2'd0, 8'h3C);
    cpu_write(2'd0, 8'hC3);
    cpu_write(2'd2, 8'd1);
    wait_xfer(n0, ok);
    checks++; if (!ok) $display("FAIL ovr_timeout: got no completion want completion"); else passed++;
    e = exp_mosi_q.pop_front();
    checks++; if (mon_shift !== e) $display("FAIL ovr_mosi: got %h want %h", mon_shift, e); else passed++;
    checks++; if (last_len != 48) $display("FAIL ovr_busy_len: got %0d want 48", last_len); else passed++;
    cpu_read(2'd0, v);
    e = exp_rx_q.pop_front();
    checks++; if (v !== e) $display("FAIL ovr_data: got %h want %h", v, e); else passed++;
    cpu_read(2'd1, v);
    checks++; if (v !== 8'h78) $display("FAIL ovr_stat_set: got %h want 78", v); else passed++;
    repeat (4) @(negedge phi);
    checks++; if (busy !== 1'b0 || mon_bits != 8) $display("FAIL ovr_no_second: got busy=%b bits=%0d want busy=0 bits=8", busy, mon_bits); else passed++;
    cpu_write(2'd1, 8'h80);
    cpu_read(2'd1, v);
    checks++; if (v !== 8'h18) $display("FAIL ovr_stat_clr: got %h want 18", v); else passed++;
    cpu_read(2'd2, v);
    checks++; if (v !== 8'd1) $display("FAIL ovr_div_stored: got %h want 01", v); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] v, e, b;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      run_xfer(b, b, ok);
      checks++; if (!ok) $display("FAIL b2b_timeout[%0d]: got no completion want completion", i); else passed++;
      e = exp_mosi_q.pop_front();
      checks++; if (mon_shift !== e) $display("FAIL b2b_mosi[%0d]: got %h want %h", i, mon_shift, e); else passed++;
      checks++; if (last_len != 32) $display("FAIL b2b_busy_len[%0d]: got %0d want 32", i, last_len); else passed++;
      cpu_read(2'd0, v);
      e = exp_rx_q.pop_front();
      checks++; if (v !== e) $display("FAIL b2b_data[%0d]: got %h want %h", i, v, e); else passed++;
    end
  endtask

  task automatic test_miso_capture;
    logic [7:0] v, e;
    bit ok;
    cpu_write(2'd2, 8'd4);
    loop_mode = 1'b0;
    slave_q   = 8'h5A;
    run_xfer(8'hFF, 8'h5A, ok);
    checks++; if (!ok) $display("FAIL miso_timeout: got no completion want completion"); else passed++;
    e = exp_mosi_q.pop_front();
    checks++; if (mon_shift !== e) $display("FAIL miso_mosi: got %h want %h", mon_shift, e); else passed++;
    checks++; if (mosi_low) $display("FAIL miso_mosi_steady: got low want constant 1"); else passed++;
    checks++; if (last_len != 80) $display("FAIL miso_busy_len: got %0d want 80", last_len); else passed++;
    cpu_read(2'd0, v);
    e = exp_rx_q.pop_front();
    checks++; if (v !== e) $display("FAIL miso_data: got %h want %h", v, e); else passed++;
    loop_mode = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    int k = 0;
    cpu_write(2'd2, 8'd3);
    cpu_write(2'd1, 8'h00);
    mon_bits = 0;
    cpu_write(2'd0, 8'h96);
    while (mon_bits < 3 && k < 1000) begin
      @(negedge phi);
      k++;
    end
    checks++; if (mon_bits < 3) $display("FAIL mid_reach_bit3: got %0d bits want 3", mon_bits); else passed++;
    @(negedge phi);
    reset_n = 1'b0;
    @(posedge phi);
    #1;
    checks++; if (sd_clk !== 1'b0) $display("FAIL mid_sck: got %b want 0", sd_clk); else passed++;
    checks++; if (sd_mosi !== 1'b1) $display("FAIL mid_mosi: got %b want 1", sd_mosi); else passed++;
    checks++; if (sd_ssel_n !== 1'b1) $display("FAIL mid_ssel: got %b want 1", sd_ssel_n); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
    cpu_read(2'd0, v);
    checks++; if (v !== 8'hFF) $display("FAIL mid_data: got %h want ff", v); else passed++;
    cpu_read(2'd2, v);
    checks++; if (v !== 8'd45) $display("FAIL mid_div: got %h want 2d", v); else passed++;
    @(negedge phi);
    reset_n = 1'b1;
    repeat (2) @(negedge phi);
  endtask

  task automatic test_reset_div;
    logic [7:0] v, e;
    bit ok;
    loop_mode = 1'b1;
    run_xfer(8'h00, 8'h00, ok);
    checks++; if (!ok) $display("FAIL rdiv_timeout: got no completion want completion"); else passed++;
    e = exp_mosi_q.pop_front();
    checks++; if (mon_shift !== e) $display("FAIL rdiv_mosi: got %h want %h", mon_shift, e); else passed++;
    checks++; if (mon_bits != 8) $display("FAIL rdiv_sck_pulses: got %0d want 8", mon_bits); else passed++;
    checks++; if (first_rise != 46) $display("FAIL rdiv_first_rise: got %0d want 46", first_rise); else passed++;
    checks++; if (first_fall - first_rise != 46) $display("FAIL rdiv_half: got %0d want 46", first_fall - first_rise); else passed++;
    checks++; if (last_len != 736) $display("FAIL rdiv_busy_len: got %0d want 736", last_len); else passed++;
    cpu_read(2'd0, v);
    e = exp_rx_q.pop_front();
    checks++; if (v !== e) $display("FAIL rdiv_data: got %h want %h", v, e); else passed++;
  endtask

`ifdef SD_SPI_IRQ_EN
  task automatic test_irq;
    logic [7:0] e;
    int k = 0;
    cpu_write(2'd2, 8'd0);
    cpu_write(2'd1, 8'h82);
    repeat (2) @(negedge phi);
    checks++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq); else passed++;
    mon_bits = 0;
    exp_mosi_q.push_back(8'h81);
    cpu_write(2'd0, 8'h81);
    while (busy === 1'b1 && k < 1000) begin
      @(negedge phi);
      k++;
    end
    checks++; if (irq !== 1'b0) $display("FAIL irq_at_busy_fall: got %b want 0", irq); else passed++;
    @(negedge phi);
    checks++; if (irq !== 1'b1) $display("FAIL irq_after_busy_fall: got %b want 1", irq); else passed++;
    e = exp_mosi_q.pop_front();
    checks++; if (mon_shift !== e) $display("FAIL irq_mosi: got %h want %h", mon_shift, e); else passed++;
    cpu_write(2'd1, 8'h82);
    checks++; if (irq !== 1'b1) $display("FAIL irq_clr_same: got %b want 1", irq); else passed++;
    @(negedge phi);
    checks++; if (irq !== 1'b0) $display("FAIL irq_clr_next: got %b want 0", irq); else passed++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_overrun();
    test_back_to_back();
    test_miso_capture();
    test_reset_mid();
    test_reset_div();
`ifdef SD_SPI_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
